seven_seg_capture: RTL and testbench

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

---
 rtl/seven_seg_capture.sv | 153 +++++++++++++++
 tb/tb_seven_seg_capture.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// Recovers hex digits from a scanned 7-segment display; capture lands SETTLE_CYCLES+1 clocks after a new AN/seg value appears.
// No backpressure: the inputs are free-running, and the outputs are registered state that can be sampled at any time.
module seven_seg_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] AN,
    input  logic [6:0] seg,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit_valid,
    output logic       frame_valid,
    output logic       pattern_err,
    output logic       anode_err
);

    localparam logic [1:0] WAIT_CHANGE = 2'd0;
    localparam logic [1:0] SETTLE      = 2'd1;
    localparam logic [1:0] CAPTURED    = 2'd2;
    localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);

    logic [3:0] an_q, an_p;
    logic [6:0] seg_q, seg_p;
    logic [1:0] state;
    logic [7:0] stable_cnt;
    logic [3:0] mask, mask_next;
    logic       same, capture, an_legal, pat_legal, blank;
    logic [1:0] idx;
    logic [3:0] pat_hex;

    assign same    = (an_q == an_p) && (seg_q == seg_p);
    assign capture = (state == SETTLE) && same && (stable_cnt == SETTLE_MAX - 8'd1);
    assign blank   = (seg_q == 7'h7F);

    always_comb begin
        an_legal = 1'b1;
        idx      = 2'd0;
        case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: an_legal = 1'b0;
        endcase
    end

    always_comb begin
        pat_legal = 1'b1;
        pat_hex   = 4'h0;
        case (seg_q)
            7'h40: pat_hex = 4'h0;
            7'h79: pat_hex = 4'h1;
            7'h24: pat_hex = 4'h2;
            7'h30: pat_hex = 4'h3;
            7'h19: pat_hex = 4'h4;
            7'h12: pat_hex = 4'h5;
            7'h02: pat_hex = 4'h6;
            7'h78: pat_hex = 4'h7;
            7'h00: pat_hex = 4'h8;
            7'h10: pat_hex = 4'h9;
            7'h08: pat_hex = 4'hA;
            7'h03: pat_hex = 4'hB;
            7'h46: pat_hex = 4'hC;
            7'h21: pat_hex = 4'hD;
            7'h06: pat_hex = 4'hE;
            7'h0E: pat_hex = 4'hF;
            default: pat_legal = 1'b0;
        endcase
    end

    // A full mask is cleared first, so a capture that coincides with the frame pulse still records its bit.
    always_comb begin
        mask_next = (mask == 4'hF) ? 4'h0 : mask;
        if (capture && an_legal)
            mask_next[idx] = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            an_q        <= 4'hF;
            an_p        <= 4'hF;
            seg_q       <= 7'h7F;
            seg_p       <= 7'h7F;
            state       <= WAIT_CHANGE;
            stable_cnt  <= 8'd0;
            mask        <= 4'h0;
            digit0      <= 4'h0;
            digit1      <= 4'h0;
            digit2      <= 4'h0;
            digit3      <= 4'h0;
            digit_valid <= 4'h0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            anode_err   <= 1'b0;
        end else begin
            an_q        <= AN;
            seg_q       <= seg;
            an_p        <= an_q;
            seg_p       <= seg_q;
            mask        <= mask_next;
            frame_valid <= (mask == 4'hF);

            case (state)
                WAIT_CHANGE: begin
                    state      <= SETTLE;
                    stable_cnt <= 8'd1;
                end
                SETTLE: begin
                    if (!same) begin
                        stable_cnt <= 8'd1;
                    end else if (capture) begin
                        stable_cnt <= SETTLE_MAX;
                        state      <= CAPTURED;
                    end else if (stable_cnt != SETTLE_MAX) begin
                        stable_cnt <= stable_cnt + 8'd1;
                    end
                end
                CAPTURED: begin
                    if (!same) begin
                        state      <= SETTLE;
                        stable_cnt <= 8'd1;
                    end
                end
                default: begin
                    state      <= WAIT_CHANGE;
                    stable_cnt <= 8'd0;
                end
            endcase

            if (capture) begin
                if (!an_legal) begin
                    anode_err <= 1'b1;
                end else if (pat_legal) begin
                    digit_valid[idx] <= 1'b1;
                    case (idx)
                        2'd0: digit0 <= pat_hex;
                        2'd1: digit1 <= pat_hex;
                        2'd2: digit2 <= pat_hex;
                        default: digit3 <= pat_hex;
                    endcase
                end else begin
                    digit_valid[idx] <= 1'b0;
                    if (!blank)
                        pattern_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: table of scan steps with expected display state, plus reset sequences.
module tb_seven_seg_capture;

    localparam int NV = 21;

    logic       Clk;
    logic       Reset;
    logic [3:0] AN;
    logic [6:0] seg;
    logic [3:0] digit0, digit1, digit2, digit3, digit_valid;
    logic       frame_valid, pattern_err, anode_err;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] dig;
        logic [3:0]  dv;
        logic        perr;
        logic        aerr;
        int          frames;
    } vec_t;

    vec_t vecs[NV];
    vec_t sb[$];
    vec_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frame_cnt = 0;

    seven_seg_capture #(.SETTLE_CYCLES(4)) dut (
        .Clk(Clk), .Reset(Reset), .AN(AN), .seg(seg),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .digit_valid(digit_valid), .frame_valid(frame_valid),
        .pattern_err(pattern_err), .anode_err(anode_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk)
        if (frame_valid) frame_cnt <= frame_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int cycles);
        AN  = a;
        seg = s;
        repeat (cycles) @(negedge Clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " digits"}, 32'({digit3, digit2, digit1, digit0}), 32'h0);
        check({tag, " digit_valid"}, 32'(digit_valid), 32'h0);
        check({tag, " frame_valid"}, 32'(frame_valid), 32'h0);
        check({tag, " pattern_err"}, 32'(pattern_err), 32'h0);
        check({tag, " anode_err"}, 32'(anode_err), 32'h0);
    endtask

    initial begin
        //               an       seg    hold digits    dv       perr  aerr  frames
        vecs[0]  = '{4'b1110, 7'h40, 3, 16'h0000, 4'b0000, 1'b0, 1'b0, 0};
        vecs[1]  = '{4'b1110, 7'h79, 8, 16'h0001, 4'b0001, 1'b0, 1'b0, 0};
        vecs[2]  = '{4'b1101, 7'h24, 8, 16'h0021, 4'b0011, 1'b0, 1'b0, 0};
        vecs[3]  = '{4'b1011, 7'h30, 8, 16'h0321, 4'b0111, 1'b0, 1'b0, 0};
        vecs[4]  = '{4'b0111, 7'h08, 8, 16'hA321, 4'b1111, 1'b0, 1'b0, 1};
        vecs[5]  = '{4'b1110, 7'h19, 8, 16'hA324, 4'b1111, 1'b0, 1'b0, 1};
        vecs[6]  = '{4'b1101, 7'h12, 8, 16'hA354, 4'b1111, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'b1011, 7'h02, 8, 16'hA654, 4'b1111, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'b0111, 7'h46, 8, 16'hC654, 4'b1111, 1'b0, 1'b0, 2};
        vecs[9]  = '{4'b1110, 7'h78, 8, 16'hC657, 4'b1111, 1'b0, 1'b0, 2};
        vecs[10] = '{4'b1101, 7'h00, 8, 16'hC687, 4'b1111, 1'b0, 1'b0, 2};
        vecs[11] = '{4'b1011, 7'h10, 8, 16'hC987, 4'b1111, 1'b0, 1'b0, 2};
        vecs[12] = '{4'b0111, 7'h7F, 8, 16'hC987, 4'b0111, 1'b0, 1'b0, 3};
        vecs[13] = '{4'b1101, 7'h55, 8, 16'hC987, 4'b0101, 1'b1, 1'b0, 3};
        vecs[14] = '{4'b1100, 7'h40, 8, 16'hC987, 4'b0101, 1'b1, 1'b1, 3};
        vecs[15] = '{4'b1110, 7'h08, 8, 16'hC98A, 4'b0101, 1'b1, 1'b1, 3};
        vecs[16] = '{4'b1011, 7'h21, 8, 16'hCD8A, 4'b0101, 1'b1, 1'b1, 3};
        vecs[17] = '{4'b0111, 7'h0E, 8, 16'hFD8A, 4'b1101, 1'b1, 1'b1, 4};
        vecs[18] = '{4'b1101, 7'h03, 8, 16'hFDBA, 4'b1111, 1'b1, 1'b1, 4};
        vecs[19] = '{4'b1110, 7'h06, 8, 16'hFDBE, 4'b1111, 1'b1, 1'b1, 4};
        vecs[20] = '{4'b1011, 7'h40, 8, 16'hF0BE, 4'b1111, 1'b1, 1'b1, 4};

        Reset = 1'b1;
        AN    = 4'hF;
        seg   = 7'h7F;
        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            AN  = vecs[i].an;
            seg = vecs[i].seg;
            sb.push_back(vecs[i]);
            repeat (vecs[i].hold) @(negedge Clk);
            e = sb.pop_front();
            check($sformatf("step%0d digits", i), 32'({digit3, digit2, digit1, digit0}), 32'(e.dig));
            check($sformatf("step%0d digit_valid", i), 32'(digit_valid), 32'(e.dv));
            check($sformatf("step%0d pattern_err", i), 32'(pattern_err), 32'(e.perr));
            check($sformatf("step%0d anode_err", i), 32'(anode_err), 32'(e.aerr));
            check($sformatf("step%0d frames", i), 32'(frame_cnt), 32'(e.frames));
        end

        // Reset clears the sticky error flags.
        Reset = 1'b1;
        AN    = 4'hF;
        seg   = 7'h7F;
        repeat (2) @(negedge Clk);
        check_all_zero("reset2");
        Reset = 1'b0;

        // Reset lands on the capture edge of the third digit.
        drive(4'b1110, 7'h79, 8);
        drive(4'b1101, 7'h24, 8);
        check("pre_reset digit_valid", 32'(digit_valid), 32'h3);
        drive(4'b1011, 7'h30, 4);
        Reset = 1'b1;
        @(negedge Clk);
        check_all_zero("mid_capture_reset");
        check("mid_capture_reset frames", 32'(frame_cnt), 32'd4);
        Reset = 1'b0;

        drive(4'b1110, 7'h79, 8);
        drive(4'b1101, 7'h24, 8);
        drive(4'b1011, 7'h30, 8);
        drive(4'b0111, 7'h08, 8);
        check("rescan digits", 32'({digit3, digit2, digit1, digit0}), 32'hA321);
        check("rescan digit_valid", 32'(digit_valid), 32'hF);
        check("rescan frames", 32'(frame_cnt), 32'd5);

        // A long hold must not produce further frames or changes.
        drive(4'b0111, 7'h08, 40);
        check("hold frames", 32'(frame_cnt), 32'd5);
        check("hold digits", 32'({digit3, digit2, digit1, digit0}), 32'hA321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
